// File: rtl/veririsc_pkg.sv
// Shared VeriRISC definitions: opcodes, phase encodings and the ALU-op class.
package veririsc_pkg;

  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned PHASE_W  = 3;

  // Opcodes
  localparam logic [OPCODE_W-1:0] HLT = 3'd0;
  localparam logic [OPCODE_W-1:0] SKZ = 3'd1;
  localparam logic [OPCODE_W-1:0] ADD = 3'd2;
  localparam logic [OPCODE_W-1:0] AND = 3'd3;
  localparam logic [OPCODE_W-1:0] XOR = 3'd4;
  localparam logic [OPCODE_W-1:0] LDA = 3'd5;
  localparam logic [OPCODE_W-1:0] STO = 3'd6;
  localparam logic [OPCODE_W-1:0] JMP = 3'd7;

  // Fetch/execute phases
  localparam logic [PHASE_W-1:0] INST_ADDR  = 3'd0;
  localparam logic [PHASE_W-1:0] INST_FETCH = 3'd1;
  localparam logic [PHASE_W-1:0] INST_LOAD  = 3'd2;
  localparam logic [PHASE_W-1:0] IDLE       = 3'd3;
  localparam logic [PHASE_W-1:0] OP_ADDR    = 3'd4;
  localparam logic [PHASE_W-1:0] OP_FETCH   = 3'd5;
  localparam logic [PHASE_W-1:0] ALU_OP     = 3'd6;
  localparam logic [PHASE_W-1:0] STORE      = 3'd7;

  // Opcodes that read a memory operand into the accumulator path
  function automatic logic is_aluop(input logic [OPCODE_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/phase_counter.sv
// 3-bit wrapping phase counter with enable and async active-high reset.
module phase_counter
  import veririsc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  output logic [PHASE_W-1:0] phase
);

  // Advance one phase per enabled cycle, wrapping 7 -> 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= INST_ADDR;
    end else if (en) begin
      phase <= phase + PHASE_W'(1);
    end
  end

endmodule

// File: rtl/veririsc_controller.sv
// VeriRISC instruction sequencer: phase stepping, halt latch and strobe decode.
// Optional build macro VERIRISC_CTRL_STEP_EN adds a 'step' input that gates
// phase advance (single-step / stall support).
module veririsc_controller
  import veririsc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
`ifdef VERIRISC_CTRL_STEP_EN
  input  logic                step,
`endif
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  output logic [PHASE_W-1:0]  phase,
  output logic                sel,
  output logic                rd,
  output logic                ld_ir,
  output logic                inc_pc,
  output logic                halt,
  output logic                ld_pc,
  output logic                data_e,
  output logic                ld_ac,
  output logic                wr
);

  logic halted;
  logic cycle_en;
  logic halt_set;
  logic aluop;

  // Enabled cycle: not halted (and step asserted when single-stepping exists)
`ifdef VERIRISC_CTRL_STEP_EN
  assign cycle_en = step && !halted;
`else
  assign cycle_en = !halted;
`endif

  // HLT latches at the end of OP_ADDR; phase then stays parked at OP_ADDR
  assign halt_set = cycle_en && (phase == OP_ADDR) && (opcode == HLT);
  assign aluop    = is_aluop(opcode);

  phase_counter u_phase_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (cycle_en && !halt_set),
    .phase (phase)
  );

  // Halt latch, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted <= 1'b0;
    end else if (halt_set) begin
      halted <= 1'b1;
    end
  end

  // Strobe decode from phase, live opcode, zero flag and halt state
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (phase)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = aluop;
        end
        ALU_OP: begin
          rd     = aluop;
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = aluop;
          ld_ac  = aluop;
          ld_pc  = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_veririsc_controller.sv
// Directed self-checking bench for veririsc_controller.
module tb_veririsc_controller;

  typedef logic [8:0] vec8_t [8];

  logic       clk;
  logic       rst;
  logic       step;
  logic [2:0] opcode;
  logic       zero;
  logic [2:0] phase;
  logic       sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
  logic [8:0] strobes;

  int passes = 0;
  int total  = 0;

  veririsc_controller dut (
    .clk    (clk),
    .rst    (rst),
`ifdef VERIRISC_CTRL_STEP_EN
    .step   (step),
`endif
    .opcode (opcode),
    .zero   (zero),
    .phase  (phase),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr)
  );

  // Strobe order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  assign strobes = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk one instruction, checking phase and strobes at every phase
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input vec8_t exp);
    opcode = op;
    zero   = z;
    for (int p = 0; p < 8; p++) begin
      check($sformatf("%s_phase%0d", name, p), 16'(phase), 16'(p));
      check($sformatf("%s_strobes_p%0d", name, p), 16'(strobes), 16'(exp[p]));
      tick();
    end
    check($sformatf("%s_wrap", name), 16'(phase), 16'd0);
  endtask

  vec8_t exp_add, exp_skz1, exp_skz0, exp_sto, exp_jmp;

  initial begin
    exp_add  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                 9'b000100000, 9'b010000000, 9'b010000000, 9'b010000010};
    exp_skz1 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                 9'b000100000, 9'b000000000, 9'b000100000, 9'b000000000};
    exp_skz0 = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                 9'b000100000, 9'b000000000, 9'b000000000, 9'b000000000};
    exp_sto  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                 9'b000100000, 9'b000000000, 9'b000000100, 9'b000000101};
    exp_jmp  = '{9'b100000000, 9'b110000000, 9'b111000000, 9'b111000000,
                 9'b000100000, 9'b000000000, 9'b000001000, 9'b000001000};

    rst    = 1'b1;
    step   = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;
    #12;
    check("reset_phase", 16'(phase), 16'd0);
    check("reset_strobes", 16'(strobes), 16'h100);
    rst = 1'b0;
    tick();
    check("first_edge_phase", 16'(phase), 16'd1);

    // Advance to phase 5, then reset asynchronously between edges
    repeat (4) tick();
    check("pre_reset_phase5", 16'(phase), 16'd5);
    rst = 1'b1;
    #1;
    check("midreset_phase", 16'(phase), 16'd0);
    check("midreset_strobes", 16'(strobes), 16'h100);
    check("midreset_halt", 16'(halt), 16'd0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    check("post_reset_phase", 16'(phase), 16'd1);
    repeat (7) tick();
    check("aligned_phase0", 16'(phase), 16'd0);

    run_instr("add",  3'd2, 1'b0, exp_add);
    run_instr("skz_z1", 3'd1, 1'b1, exp_skz1);
    run_instr("skz_z0", 3'd1, 1'b0, exp_skz0);
    run_instr("sto",  3'd6, 1'b0, exp_sto);
    run_instr("jmp",  3'd7, 1'b0, exp_jmp);

`ifdef VERIRISC_CTRL_STEP_EN
    // Stall for 5 cycles in phase 2: phase and decode hold
    opcode = 3'd2;
    repeat (2) tick();
    step = 1'b0;
    repeat (5) tick();
    check("step_hold_phase", 16'(phase), 16'd2);
    check("step_hold_strobes", 16'(strobes), 16'h1C0);
    step = 1'b1;
    tick();
    check("step_resume_phase", 16'(phase), 16'd3);
    repeat (5) tick();
    check("step_realign", 16'(phase), 16'd0);
`endif

    // HLT: halt rises in phase 4 and the machine parks there
    opcode = 3'd0;
    repeat (4) tick();
    check("hlt_phase4", 16'(phase), 16'd4);
    check("hlt_p4_strobes", 16'(strobes), 16'h030);
    tick();
    check("hlt_latched_phase", 16'(phase), 16'd4);
    check("hlt_latched_strobes", 16'(strobes), 16'h010);
    repeat (20) tick();
    check("hlt_hold_phase", 16'(phase), 16'd4);
    check("hlt_hold_halt", 16'(halt), 16'd1);
    check("hlt_hold_inc_pc", 16'(inc_pc), 16'd0);
    check("hlt_hold_sel", 16'(sel), 16'd0);

    // Opcode change while halted must not release the halt
    opcode = 3'd2;
    tick();
    check("hlt_sticky", 16'(strobes), 16'h010);

    rst = 1'b1;
    #1;
    check("hlt_reset_phase", 16'(phase), 16'd0);
    check("hlt_reset_halt", 16'(halt), 16'd0);
    check("hlt_reset_strobes", 16'(strobes), 16'h100);
    #1;
    rst = 1'b0;
    tick();
    check("hlt_restart_phase", 16'(phase), 16'd1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/veririsc_controller.md
# veririsc_controller

Instruction sequencer for the VeriRISC CPU. It steps an internal 3-bit phase counter through the 8-phase fetch/execute cycle and decodes phase, opcode and the accumulator zero flag into the datapath control strobes. Those strobes include `sel`, the select of the PC/IR-address multiplexor that feeds the memory address bus. It sits between the instruction register / ALU zero flag and the PC, accumulator, memory and address mux.

## Interface
Parameters:
- none (widths fixed by the ISA: 3-bit opcode, 3-bit phase)

Ports:
- `clk` input 1: system clock, rising-edge.
- `rst` input 1: reset, asynchronous and active-high.
- `opcode` input 3: current IR opcode field.
- `zero` input 1: accumulator-is-zero flag.
- `phase` output 3: current phase (observability).
- `sel` output 1: address mux select; 1 = PC, 0 = IR operand address.
- `rd` output 1: memory read enable.
- `ld_ir` output 1: load instruction register.
- `inc_pc` output 1: increment PC.
- `halt` output 1: CPU halted / halting.
- `ld_pc` output 1: load PC (jump).
- `data_e` output 1: drive accumulator onto data bus.
- `ld_ac` output 1: load accumulator.
- `wr` output 1: memory write enable.

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `ALUOP` = ADD, AND, XOR or LDA.
- Phase counter advances by 1 per enabled cycle and wraps 7→0. Enabled cycle: every cycle while not halted; see Configuration.
- Outputs are a combinational decode of (phase, opcode, zero, halted). Any strobe not listed for a phase is 0.
  - 0 INST_ADDR: `sel`=1.
  - 1 INST_FETCH: `sel`=1, `rd`=1.
  - 2 INST_LOAD: `sel`=1, `rd`=1, `ld_ir`=1.
  - 3 IDLE: `sel`=1, `rd`=1, `ld_ir`=1.
  - 4 OP_ADDR: `inc_pc`=1, `halt`=(opcode==HLT).
  - 5 OP_FETCH: `rd`=ALUOP.
  - 6 ALU_OP: `rd`=ALUOP, `inc_pc`=(SKZ && zero), `ld_pc`=JMP, `data_e`=STO.
  - 7 STORE: `rd`=ALUOP, `ld_ac`=ALUOP, `ld_pc`=JMP, `wr`=STO, `data_e`=STO.
- Halt:
  - At the enabled edge ending phase 4 with opcode HLT, the `halted` register sets and phase holds at 4.
  - While `halted`=1: `halt`=1, all other strobes 0 (including `sel` and `inc_pc`), and the phase is frozen.
  - Only `rst` clears `halted`.
- Opcode is used live. IR loads at the end of phase 2, so decode is valid from phase 3 onward; phases 0–3 decode independently of opcode.

## Timing
- Reset (async, immediate): phase=0, halted=0. Outputs therefore show the phase-0 decode: `sel`=1, all other strobes 0.
- Reset mid-instruction, including while halted: same values, asserted asynchronously without waiting for a clock edge.
- First rising edge after `rst` deasserts: phase 0→1.
- One full instruction takes 8 enabled cycles.
- Strobes change only after phase edges or input changes, with zero added clock latency. They are valid a combinational delay after `clk`, `opcode` or `zero` changes.
- `halt` rises combinationally in phase 4 of an HLT instruction and stays high after the edge, with no glitch to 0.

## Configuration
- Macro `VERIRISC_CTRL_STEP_EN`.
- Defined: adds port `step` (input, 1 bit). An enabled cycle is one with `step`=1 and `halted`=0. With `step`=0 the phase holds and the decode for the held phase stays on the outputs.
- Undefined: no `step` port; every non-halted cycle is enabled.
- Halt and reset behaviour are identical in both builds.

## Structure
- Shared package `veririsc_pkg` holds:
  - opcode localparams (HLT..JMP);
  - phase encodings (INST_ADDR..STORE);
  - the ALUOP membership function.
- One sub-module, `phase_counter`:
  - 3-bit wrap counter with async active-high reset and an enable input;
  - reused by this block only.
- Decode and halt latch live in `veririsc_controller`.

## Test plan
- Reset with `rst`=1 asserted mid-phase 5 → phase=0 immediately, `sel`=1, all other strobes 0, `halt`=0.
- Run 8 cycles with opcode=ADD (2), `zero`=0 → `rd` asserted in phases 1,2,3,5,6,7; `ld_ir` in 2,3; `inc_pc` in 4 only; `ld_ac` in 7 only; `wr`=0 throughout.
- opcode=SKZ (1):
  - `zero`=1 → `inc_pc` in phase 4 and phase 6.
  - `zero`=0 → `inc_pc` in phase 4 only.
- opcode=STO (6) → `data_e`=1 in phases 6,7; `wr`=1 in phase 7 only; `rd`=0 in phases 5–7.
- opcode=JMP (7) → `ld_pc`=1 in phases 6,7; after 8 cycles phase wraps to 0.
- opcode=HLT (0):
  - `halt`=1 from phase 4.
  - After 20 further clocks: phase stays 4, `halt`=1, `inc_pc`=0, `sel`=0.
  - Pulse `rst` → phase 0, `halt`=0.
  - With `VERIRISC_CTRL_STEP_EN`: `step`=0 for 5 cycles holds the phase.
